// File: rtl/fft_pkg.sv
// Shared constants for the radix-2 butterfly datapath: default widths, mode encodings
// and the rounding/saturation parameters used by the pipeline stages.
package fft_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_TW_WIDTH = 16;

  typedef enum logic {
    MODE_DIF = 1'b0,
    MODE_DIT = 1'b1
  } mode_e;

  // Sums/differences carry two guard bits so nothing wraps before saturation.
  localparam int SUM_GUARD   = 2;
  localparam int SCALE_RND   = 1;
  localparam int SCALE_SHIFT = 1;

  // Twiddles are Q1.(tw-1): product is shifted back by tw-1, rounding at bit tw-2.
  function automatic int prod_shift(input int tw_width);
    return tw_width - 1;
  endfunction

  function automatic int prod_rnd_pos(input int tw_width);
    return tw_width - 2;
  endfunction

endpackage

// File: rtl/cmult_pipe.sv
// One-cycle complex multiplier with round-half-up back to the data scale.
// Holds its output register while en is low.
module cmult_pipe
  import fft_pkg::*;
#(
  parameter int IW = 18,
  parameter int TW = 16,
  parameter int OW = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic signed [IW-1:0] x_r,
  input  logic signed [IW-1:0] x_i,
  input  logic signed [TW-1:0] w_r,
  input  logic signed [TW-1:0] w_i,
  output logic signed [OW-1:0] p_r,
  output logic signed [OW-1:0] p_i
);

  localparam int PW = IW + TW + 1;
  localparam logic signed [PW-1:0] RND = PW'(1) <<< prod_rnd_pos(TW);

  logic signed [PW-1:0] full_r, full_i;
  logic signed [OW-1:0] p_r_d, p_r_q, p_i_d, p_i_q;

  always_comb begin
    full_r = PW'(x_r) * PW'(w_r) - PW'(x_i) * PW'(w_i);
    full_i = PW'(x_r) * PW'(w_i) + PW'(x_i) * PW'(w_r);
    p_r_d  = p_r_q;
    p_i_d  = p_i_q;
    if (en) begin
      p_r_d = OW'((full_r + RND) >>> prod_shift(TW));
      p_i_d = OW'((full_i + RND) >>> prod_shift(TW));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r_q <= '0;
      p_i_q <= '0;
    end else begin
      p_r_q <= p_r_d;
      p_i_q <= p_i_d;
    end
  end

  assign p_r = p_r_q;
  assign p_i = p_i_q;

endmodule

// File: rtl/pipe_butterfly.sv
// Three-stage radix-2 DIF/DIT butterfly with valid/ready handshake, optional halving,
// output saturation and a sticky overflow flag.
module pipe_butterfly
  import fft_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int TW_WIDTH = DEF_TW_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       mode,
  input  logic                       scale_en,
  input  logic signed [WIDTH-1:0]    a_r,
  input  logic signed [WIDTH-1:0]    a_i,
  input  logic signed [WIDTH-1:0]    b_r,
  input  logic signed [WIDTH-1:0]    b_i,
  input  logic signed [TW_WIDTH-1:0] w_r,
  input  logic signed [TW_WIDTH-1:0] w_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [WIDTH-1:0]    y0_r,
  output logic signed [WIDTH-1:0]    y0_i,
  output logic signed [WIDTH-1:0]    y1_r,
  output logic signed [WIDTH-1:0]    y1_i,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int W2 = WIDTH + SUM_GUARD;
  localparam int WP = W2 + 2;
  localparam int SW = WP + 1;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic en;
  logic v1_d, v1_q, v2_d, v2_q, sc1_d, sc1_q, sc2_d, sc2_q;
  mode_e mode1_d, mode1_q, mode2_d, mode2_q;
  logic signed [W2-1:0] x0r1_d, x0r1_q, x0i1_d, x0i1_q, mr1_d, mr1_q, mi1_d, mi1_q;
  logic signed [W2-1:0] x0r2_d, x0r2_q, x0i2_d, x0i2_q;
  logic signed [TW_WIDTH-1:0] wr1_d, wr1_q, wi1_d, wi1_q;
  logic signed [WP-1:0] p_r, p_i;
  logic signed [SW-1:0] s0r, s0i, s1r, s1i;
  logic out_valid_d, out_valid_q, ovf_d, ovf_q, sat_any;
  logic signed [WIDTH-1:0] y0r_d, y0r_q, y0i_d, y0i_q, y1r_d, y1r_q, y1i_d, y1i_q;

  function automatic logic signed [SW-1:0] scl(input logic signed [SW-1:0] v, input logic s);
    return s ? (v + SW'(SCALE_RND)) >>> SCALE_SHIFT : v;
  endfunction

  function automatic logic is_sat(input logic signed [SW-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[WIDTH-1:0];
    if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  cmult_pipe #(.IW(W2), .TW(TW_WIDTH), .OW(WP)) u_cmult (
    .clk(clk), .rst_n(rst_n), .en(en),
    .x_r(mr1_q), .x_i(mi1_q), .w_r(wr1_q), .w_i(wi1_q),
    .p_r(p_r), .p_i(p_i)
  );

  // S3 pre-saturation results; DIF already has y0 in x0 and y1 in p.
  always_comb begin
    s0r = SW'(x0r2_q);
    s0i = SW'(x0i2_q);
    s1r = SW'(p_r);
    s1i = SW'(p_i);
    if (mode2_q == MODE_DIT) begin
      s0r = SW'(x0r2_q) + SW'(p_r);
      s0i = SW'(x0i2_q) + SW'(p_i);
      s1r = SW'(x0r2_q) - SW'(p_r);
      s1i = SW'(x0i2_q) - SW'(p_i);
    end
    s0r = scl(s0r, sc2_q);
    s0i = scl(s0i, sc2_q);
    s1r = scl(s1r, sc2_q);
    s1i = scl(s1i, sc2_q);
    sat_any = is_sat(s0r) || is_sat(s0i) || is_sat(s1r) || is_sat(s1i);
  end

  always_comb begin
    v1_d = v1_q;  mode1_d = mode1_q;  sc1_d = sc1_q;
    x0r1_d = x0r1_q;  x0i1_d = x0i1_q;  mr1_d = mr1_q;  mi1_d = mi1_q;
    wr1_d = wr1_q;  wi1_d = wi1_q;
    v2_d = v2_q;  mode2_d = mode2_q;  sc2_d = sc2_q;  x0r2_d = x0r2_q;  x0i2_d = x0i2_q;
    out_valid_d = out_valid_q;
    y0r_d = y0r_q;  y0i_d = y0i_q;  y1r_d = y1r_q;  y1i_d = y1i_q;
    if (en) begin
      v1_d    = in_valid;
      mode1_d = mode_e'(mode);
      sc1_d   = scale_en;
      wr1_d   = w_r;
      wi1_d   = w_i;
      if (mode_e'(mode) == MODE_DIT) begin
        x0r1_d = W2'(a_r);  x0i1_d = W2'(a_i);
        mr1_d  = W2'(b_r);  mi1_d  = W2'(b_i);
      end else begin
        x0r1_d = W2'(a_r) + W2'(b_r);  x0i1_d = W2'(a_i) + W2'(b_i);
        mr1_d  = W2'(a_r) - W2'(b_r);  mi1_d  = W2'(a_i) - W2'(b_i);
      end
      v2_d = v1_q;  mode2_d = mode1_q;  sc2_d = sc1_q;  x0r2_d = x0r1_q;  x0i2_d = x0i1_q;
      out_valid_d = v2_q;
      if (v2_q) begin
        y0r_d = sat(s0r);  y0i_d = sat(s0i);  y1r_d = sat(s1r);  y1i_d = sat(s1i);
      end
    end
    ovf_d = (ovf_q && !ovf_clr) || (en && v2_q && sat_any);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;  mode1_q <= MODE_DIF;  sc1_q <= 1'b0;
      x0r1_q <= '0;  x0i1_q <= '0;  mr1_q <= '0;  mi1_q <= '0;  wr1_q <= '0;  wi1_q <= '0;
      v2_q <= 1'b0;  mode2_q <= MODE_DIF;  sc2_q <= 1'b0;  x0r2_q <= '0;  x0i2_q <= '0;
      out_valid_q <= 1'b0;  ovf_q <= 1'b0;
      y0r_q <= '0;  y0i_q <= '0;  y1r_q <= '0;  y1i_q <= '0;
    end else begin
      v1_q <= v1_d;  mode1_q <= mode1_d;  sc1_q <= sc1_d;
      x0r1_q <= x0r1_d;  x0i1_q <= x0i1_d;  mr1_q <= mr1_d;  mi1_q <= mi1_d;
      wr1_q <= wr1_d;  wi1_q <= wi1_d;
      v2_q <= v2_d;  mode2_q <= mode2_d;  sc2_q <= sc2_d;  x0r2_q <= x0r2_d;  x0i2_q <= x0i2_d;
      out_valid_q <= out_valid_d;  ovf_q <= ovf_d;
      y0r_q <= y0r_d;  y0i_q <= y0i_d;  y1r_q <= y1r_d;  y1i_q <= y1i_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign y0_r      = y0r_q;
  assign y0_i      = y0i_q;
  assign y1_r      = y1r_q;
  assign y1_i      = y1i_q;

endmodule

// File: tb/tb_pipe_butterfly.sv
// Directed bench for pipe_butterfly: known vectors, saturation/ovf, stall stream and
// mid-flight reset.
module tb_pipe_butterfly;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, mode, scale_en, out_valid, out_ready, ovf, ovf_clr;
  logic signed [15:0] a_r, a_i, b_r, b_i, w_r, w_i, y0_r, y0_i, y1_r, y1_i;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_butterfly #(.WIDTH(16), .TW_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .scale_en(scale_en),
    .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i), .w_r(w_r), .w_i(w_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0_r(y0_r), .y0_i(y0_i), .y1_r(y1_r), .y1_i(y1_i),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic md, input logic sc, input int ar, input int ai,
                       input int br, input int bi, input int wr, input int wi);
    mode = md;  scale_en = sc;
    a_r = 16'(ar);  a_i = 16'(ai);  b_r = 16'(br);  b_i = 16'(bi);
    w_r = 16'(wr);  w_i = 16'(wi);
  endtask

  // Presents one transaction and returns just after the edge that should raise out_valid.
  task automatic run_txn(input logic md, input logic sc, input int ar, input int ai,
                         input int br, input int bi, input int wr, input int wi,
                         input logic clr_at_out);
    @(posedge clk); #1;
    drive(md, sc, ar, ai, br, bi, wr, wi);
    in_valid = 1'b1;  out_ready = 1'b1;
    @(negedge clk);
    check_val("txn_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("lat_s1_no_out", out_valid, 0);
    @(posedge clk); #1;
    check_val("lat_s2_no_out", out_valid, 0);
    if (clr_at_out) ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check_val("lat_out_valid", out_valid, 1);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check_val("ovf_cleared", ovf, 0);
  endtask

  function automatic int exp_y(input int k, input int idx);
    int h;
    h = (k + 1) / 2;
    if (k % 2 == 1) begin
      case (idx)
        0: return 100 * k + h;
        1: return k;
        2: return 100 * k - h;
        default: return k;
      endcase
    end
    case (idx)
      0: return 101 * k;
      1: return k;
      2: return (99 * k + 1) / 2;
      default: return h;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, got, k;
    logic held;
    logic signed [15:0] h0r, h0i, h1r, h1i;

    rst_n = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;  ovf_clr = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_y0_r", y0_r, 0);
    check_val("rst_y1_i", y1_i, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);

    run_txn(0, 0, 1000, 0, 200, 0, 16384, 0, 0);
    check_val("dif_y0_r", y0_r, 1200);
    check_val("dif_y0_i", y0_i, 0);
    check_val("dif_y1_r", y1_r, 400);
    check_val("dif_y1_i", y1_i, 0);
    check_val("dif_ovf", ovf, 0);

    run_txn(1, 0, 0, 0, 100, 50, 0, -32768, 0);
    check_val("dit_y0_r", y0_r, 50);
    check_val("dit_y0_i", y0_i, -100);
    check_val("dit_y1_r", y1_r, -50);
    check_val("dit_y1_i", y1_i, 100);
    check_val("dit_ovf", ovf, 0);

    run_txn(0, 0, 32767, 0, 1, 0, 16384, 0, 0);
    check_val("sat_y0_r", y0_r, 32767);
    check_val("sat_y1_r", y1_r, 16383);
    check_val("sat_ovf", ovf, 1);

    run_txn(0, 1, 32767, 0, 1, 0, 16384, 0, 0);
    check_val("scale_y0_r", y0_r, 16384);
    check_val("scale_y1_r", y1_r, 8192);
    check_val("scale_ovf_kept", ovf, 1);
    pulse_clr();

    run_txn(0, 0, 32767, 0, 1, 0, 16384, 0, 1);
    check_val("clr_vs_sat_ovf", ovf, 1);
    pulse_clr();

    run_txn(0, 0, -32768, 0, -1, 0, 16384, 0, 0);
    check_val("negsat_y0_r", y0_r, -32768);
    check_val("negsat_y1_r", y1_r, -16383);
    check_val("negsat_ovf", ovf, 1);
    pulse_clr();

    // Stream of 8 with out_ready low for cycles 4..8; odd k are DIT, even k DIF.
    acc = 0;  got = 0;  held = 1'b0;
    h0r = '0;  h0i = '0;  h1r = '0;  h1i = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 4 && c <= 8);
      if (acc < 8) begin
        k = acc + 1;
        drive(logic'(k % 2), 0, 100 * k, k, k, 0, 16384, 0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 4 && c <= 8) check_val("stall_in_ready", in_ready, 0);
      if (held) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_y0_r", y0_r, h0r);
        check_val("hold_y0_i", y0_i, h0i);
        check_val("hold_y1_r", y1_r, h1r);
        check_val("hold_y1_i", y1_i, h1i);
      end
      if (out_valid && out_ready) begin
        check_val("strm_y0_r", y0_r, exp_y(got + 1, 0));
        check_val("strm_y0_i", y0_i, exp_y(got + 1, 1));
        check_val("strm_y1_r", y1_r, exp_y(got + 1, 2));
        check_val("strm_y1_i", y1_i, exp_y(got + 1, 3));
        got++;
        held = 1'b0;
      end else if (out_valid) begin
        held = 1'b1;
        h0r = y0_r;  h0i = y0_i;  h1r = y1_r;  h1i = y1_i;
      end else begin
        held = 1'b0;
      end
      if (in_valid && in_ready) acc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("strm_count", got, 8);
    check_val("strm_accepted", acc, 8);

    // Reset with one result held at the output and another in S2.
    @(posedge clk); #1;
    drive(0, 0, 32767, 0, 1, 0, 16384, 0);
    in_valid = 1'b1;  out_ready = 1'b1;
    @(posedge clk); #1;
    drive(0, 0, 10, 0, 5, 0, 16384, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;  out_ready = 1'b0;
    @(posedge clk); #1;
    check_val("pre_rst_valid", out_valid, 1);
    check_val("pre_rst_ovf", ovf, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_valid", out_valid, 0);
    check_val("async_rst_ovf", ovf, 0);
    check_val("async_rst_y0_r", y0_r, 0);
    out_ready = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_in_ready", in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_val("no_stale_out", out_valid, 0);
    end
    run_txn(0, 0, 5, 6, 1, 2, 16384, 0, 0);
    check_val("post_rst_y0_r", y0_r, 6);
    check_val("post_rst_y0_i", y0_i, 8);
    check_val("post_rst_y1_r", y1_r, 2);
    check_val("post_rst_y1_i", y1_i, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
